vend_txn_ctrl: RTL and testbench
================================

VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles in COLLECT before automatic refund.
REQ-002 SHALL have parameter MAX_CREDIT, default 40, meaning the credit ceiling in rupees.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port coin_valid, input, 1 bit: coin present this cycle.
REQ-006 SHALL have port coin, input, 8 bits: coin value; only 5, 10 and 20 are legal.
REQ-007 SHALL have ports T3, R2 and U1, input, 1 bit each: select Tea (5), Coffee (10) and Lemon Tea (20).
REQ-008 SHALL have port cancel, input, 1 bit: refund request.
REQ-009 SHALL have port dispense_ready, input, 1 bit: dispense mechanism accepts the request.
REQ-010 SHALL have port dispense_req, output, 1 bit: item dispense request.
REQ-011 SHALL have port dispense_item, output, 2 bits: 0 none, 1 Lemon Tea, 2 Coffee, 3 Tea.
REQ-012 SHALL have port change_valid, output, 1 bit: a change coin is emitted this cycle.
REQ-013 SHALL have port change_coin, output, 8 bits: value of the emitted coin (20, 10 or 5).
REQ-014 SHALL have port coin_reject, output, 1 bit: single-cycle pulse when an inserted coin is returned.
REQ-015 SHALL have port credit, output, 8 bits: current credit in rupees.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement a four-state FSM with states IDLE, COLLECT, DISPENSE and CHANGE.
REQ-018 SHALL handle IDLE as follows: a legal coin_valid loads credit with coin and moves to COLLECT next cycle; selections and cancel are ignored.
REQ-019 SHALL treat a coin as accepted when it is legal and credit+coin <= MAX_CREDIT; an accepted coin adds to credit.
REQ-020 SHALL reject any other coin (illegal value, overflow, or arrival in DISPENSE or CHANGE) by pulsing coin_reject the next cycle, leaving credit unchanged.
REQ-021 SHALL, in COLLECT, evaluate a selection against credit including any coin accepted in the same cycle.
REQ-022 SHALL ignore a selection when more than one of T3, R2 or U1 is high.
REQ-023 SHALL, in COLLECT, on exactly one selection with sufficient credit, subtract the price and move to DISPENSE; with insufficient credit the selection is ignored and the FSM stays in COLLECT.
REQ-024 SHALL, in COLLECT, move to CHANGE on cancel; cancel beats any selection in the same cycle, and a coin in that cycle is rejected.
REQ-025 SHALL count cycles in COLLECT with no coin_valid and no selection; reaching TIMEOUT_CYCLES forces CHANGE; any coin or selection clears the count.
REQ-026 SHALL hold dispense_req=1 and dispense_item stable in DISPENSE, from the cycle after entry until a cycle with dispense_ready=1.
REQ-027 SHALL, in the dispense_ready=1 cycle, complete the handshake; the FSM then moves to CHANGE if credit>0, else to IDLE.
REQ-028 SHALL, in CHANGE, emit one coin per cycle on change_valid=1: 20 if credit>=20, else 10 if credit>=10, else 5; the coin value is subtracted from credit.
REQ-029 SHALL move from CHANGE to IDLE in the cycle credit reaches 0; cancel and selections are ignored in CHANGE.
REQ-030 SHALL keep credit a multiple of 5 and never above MAX_CREDIT.
REQ-031 SHALL keep change_valid, dispense_req and coin_reject registered, with outputs changing only on clk edges.

Reset
REQ-032 SHALL, while reset=1, asynchronously force state=IDLE, credit=0, timeout count=0, dispense_req=0, dispense_item=0, change_valid=0, change_coin=0, coin_reject=0 and busy=0.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction: credit is discarded, no change is emitted, and dispense_req drops immediately.
REQ-034 SHALL accept no coin in the first clk edge after reset deasserts only if coin_valid is low; otherwise normal IDLE rules apply.

Structure
REQ-035 SHALL place in shared package vend_pkg: the price constants (5, 10, 20), the state enum, the dispense_item encoding and the legal coin values.
REQ-036 SHALL implement the timeout counter as sub-module vend_timeout_timer (inputs clear and enable, output expired); everything else stays in vend_txn_ctrl.

Verification
REQ-037 SHALL cover: coin 10 then R2 with dispense_ready=1 next cycle -> dispense_item=2 for one cycle, credit=0, return to IDLE, no change.
REQ-038 SHALL cover: coins 20+20 then T3 with dispense_ready delayed 3 cycles -> dispense_req held 3 cycles, then change coins 20, 10, 5 in successive cycles, then IDLE.
REQ-039 SHALL cover: coins 20+20 then coin 5 -> coin_reject pulse, credit stays 40; coin 7 in COLLECT -> coin_reject pulse.
REQ-040 SHALL cover: coin 5 then U1 -> ignored, still in COLLECT; then T3+R2 together -> ignored; then cancel -> change 5, then IDLE.
REQ-041 SHALL cover: coin 10 with no further activity for TIMEOUT_CYCLES -> change 10 emitted, then IDLE.
REQ-042 SHALL cover: reset asserted while in DISPENSE with credit 15 -> all outputs 0 immediately, no change emitted after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller.
//
// Contents:
//   - coin denominations accepted by the machine (5, 10, 20 rupees)
//   - item prices (Tea 5, Coffee 10, Lemon Tea 20)
//   - controller state enum
//   - dispense_item encoding (0 none, 1 Lemon Tea, 2 Coffee, 3 Tea)
//   - helpers for coin legality and greedy change selection
package vend_pkg;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_20 = 8'd20;

    localparam logic [7:0] PRICE_TEA    = 8'd5;
    localparam logic [7:0] PRICE_COFFEE = 8'd10;
    localparam logic [7:0] PRICE_LEMON  = 8'd20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ITEM_NONE   = 2'd0,
        ITEM_LEMON  = 2'd1,
        ITEM_COFFEE = 2'd2,
        ITEM_TEA    = 2'd3
    } item_t;

    function automatic logic isLegalCoin(input logic [7:0] value);
        return (value == COIN_5) || (value == COIN_10) || (value == COIN_20);
    endfunction

    // Largest denomination that does not exceed the remaining amount.
    // Credit is always a multiple of 5, so 5 is a safe fallback.
    function automatic logic [7:0] changeCoinFor(input logic [7:0] amount);
        if (amount >= COIN_20) begin
            return COIN_20;
        end else if (amount >= COIN_10) begin
            return COIN_10;
        end
        return COIN_5;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle timeout counter for the COLLECT phase.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset
//   clear   - restart counting from zero (activity seen, or not collecting)
//   enable  - count this cycle
//   expired - high in the TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle
//
// expired is combinational so the controller can leave COLLECT on the same
// edge that ends the last idle cycle.
module vend_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = enable && !clear && (count_q == LAST_COUNT);

    // The count wraps back to zero on expiry so it never has to hold
    // TIMEOUT_CYCLES itself.
    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending machine transaction controller.
//
// Collects coins into a credit, dispenses one selected item, and returns the
// remaining credit as change coins (greedy 20/10/5), with cancel and an idle
// timeout both forcing a refund.
//
// Ports:
//   clk, reset          - clock (rising edge), asynchronous active-high reset
//   coin_valid, coin    - inserted coin and its value (5, 10, 20 legal)
//   T3, R2, U1          - select Tea (5), Coffee (10), Lemon Tea (20)
//   cancel              - refund request while collecting
//   dispense_ready      - dispenser accepts the pending request
//   dispense_req/_item  - registered dispense request and item code
//   change_valid/_coin  - registered change coin, one per cycle
//   coin_reject         - registered pulse for a returned coin
//   credit              - current credit in rupees
//   busy                - high whenever the controller is not idle
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_CREDIT     = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [7:0] coin,
    input  logic       T3,
    input  logic       R2,
    input  logic       U1,
    input  logic       cancel,
    input  logic       dispense_ready,
    output logic       dispense_req,
    output logic [1:0] dispense_item,
    output logic       change_valid,
    output logic [7:0] change_coin,
    output logic       coin_reject,
    output logic [7:0] credit,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    item_t      item_q, item_d;
    logic       dispenseReq_q, dispenseReq_d;
    logic       changeValid_q, changeValid_d;
    logic [7:0] changeCoin_q, changeCoin_d;
    logic       coinReject_q, coinReject_d;

    logic       anySel;
    logic       oneSel;
    logic [7:0] selPrice;
    item_t      selItem;
    logic [8:0] creditPlusCoin;
    logic       coinAcceptable;
    logic [7:0] creditEff;
    logic [7:0] refundCoin;
    logic       timerClear;
    logic       timerEnable;
    logic       timerExpired;

    assign anySel = T3 || R2 || U1;
    assign oneSel = $onehot({T3, R2, U1});

    // Nine bits so an oversized coin cannot wrap and look like it fits.
    assign creditPlusCoin = {1'b0, credit_q} + {1'b0, coin};
    assign coinAcceptable = coin_valid && isLegalCoin(coin)
                            && (creditPlusCoin <= 9'(MAX_CREDIT));

    assign refundCoin = changeCoinFor(credit_q);

    always_comb begin
        selPrice = 8'd0;
        selItem  = ITEM_NONE;
        if (T3) begin
            selPrice = PRICE_TEA;
            selItem  = ITEM_TEA;
        end else if (R2) begin
            selPrice = PRICE_COFFEE;
            selItem  = ITEM_COFFEE;
        end else if (U1) begin
            selPrice = PRICE_LEMON;
            selItem  = ITEM_LEMON;
        end
    end

    // Any coin, or any selection even an ignored one, counts as activity.
    assign timerEnable = (state_q == ST_COLLECT);
    assign timerClear  = (state_q != ST_COLLECT) || coin_valid || anySel;

    vend_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    // Next-state logic. coinReject_d defaults to coin_valid so that any coin
    // not explicitly accepted below (wrong state, illegal, overflow, or
    // arriving with cancel) is handed back.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        item_d        = item_q;
        dispenseReq_d = dispenseReq_q;
        changeValid_d = 1'b0;
        changeCoin_d  = 8'd0;
        coinReject_d  = coin_valid;
        creditEff     = credit_q;

        case (state_q)
            ST_IDLE: begin
                if (coinAcceptable) begin
                    credit_d     = coin;
                    coinReject_d = 1'b0;
                    state_d      = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (cancel) begin
                    state_d = ST_CHANGE;
                end else begin
                    // A coin accepted this cycle already counts toward a
                    // selection made in the same cycle.
                    if (coinAcceptable) begin
                        creditEff    = creditPlusCoin[7:0];
                        coinReject_d = 1'b0;
                    end
                    credit_d = creditEff;
                    if (oneSel && (creditEff >= selPrice)) begin
                        credit_d      = creditEff - selPrice;
                        item_d        = selItem;
                        dispenseReq_d = 1'b1;
                        state_d       = ST_DISPENSE;
                    end else if (timerExpired) begin
                        state_d = ST_CHANGE;
                    end
                end
            end

            ST_DISPENSE: begin
                if (dispense_ready) begin
                    dispenseReq_d = 1'b0;
                    item_d        = ITEM_NONE;
                    state_d       = (credit_q != 8'd0) ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                if (credit_q != 8'd0) begin
                    changeValid_d = 1'b1;
                    changeCoin_d  = refundCoin;
                    credit_d      = credit_q - refundCoin;
                    if (credit_q == refundCoin) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= 8'd0;
            item_q        <= ITEM_NONE;
            dispenseReq_q <= 1'b0;
            changeValid_q <= 1'b0;
            changeCoin_q  <= 8'd0;
            coinReject_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            dispenseReq_q <= dispenseReq_d;
            changeValid_q <= changeValid_d;
            changeCoin_q  <= changeCoin_d;
            coinReject_q  <= coinReject_d;
        end
    end

    assign dispense_req  = dispenseReq_q;
    assign dispense_item = item_q;
    assign change_valid  = changeValid_q;
    assign change_coin   = changeCoin_q;
    assign coin_reject   = coinReject_q;
    assign credit        = credit_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed transactions followed by
// randomized traffic, all compared against a transaction-level model that
// tracks credit, a pending item and a queue of change coins still owed.
module tb_vend_txn_ctrl;

    localparam int TIMEOUT = 20;
    localparam int MAXC    = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       coinValid;
    logic [7:0] coinValue;
    logic       t3, r2, u1;
    logic       cancelReq;
    logic       dispReady;

    logic       dispenseReq;
    logic [1:0] dispenseItem;
    logic       changeValid;
    logic [7:0] changeCoin;
    logic       coinReject;
    logic [7:0] credit;
    logic       busy;

    vend_txn_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_CREDIT    (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coinValid),
        .coin          (coinValue),
        .T3            (t3),
        .R2            (r2),
        .U1            (u1),
        .cancel        (cancelReq),
        .dispense_ready(dispReady),
        .dispense_req  (dispenseReq),
        .dispense_item (dispenseItem),
        .change_valid  (changeValid),
        .change_coin   (changeCoin),
        .coin_reject   (coinReject),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: a session either collects, waits on one pending item,
    // or pays out a precomputed list of change coins.
    int mCredit;
    bit mCollecting;
    int mItem;
    int mIdle;
    int mChange[$];
    int expChgValid;
    int expChgCoin;
    int expReject;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic bit legalCoin(input int c);
        return (c == 5) || (c == 10) || (c == 20);
    endfunction

    task automatic modelReset();
        mCredit     = 0;
        mCollecting = 0;
        mItem       = 0;
        mIdle       = 0;
        mChange.delete();
        expChgValid = 0;
        expChgCoin  = 0;
        expReject   = 0;
    endtask

    // Pay back the whole credit using as few coins as possible.
    task automatic buildRefund();
        int left;
        left = mCredit;
        while (left > 0) begin
            if (left >= 20) begin
                mChange.push_back(20);
                left -= 20;
            end else if (left >= 10) begin
                mChange.push_back(10);
                left -= 10;
            end else begin
                mChange.push_back(5);
                left -= 5;
            end
        end
    endtask

    task automatic modelStep();
        int c;
        int nSel;
        int price;
        int item;
        c           = int'(coinValue);
        nSel        = int'(t3) + int'(r2) + int'(u1);
        price       = t3 ? 5 : (r2 ? 10 : 20);
        item        = t3 ? 3 : (r2 ? 2 : 1);
        expChgValid = 0;
        expChgCoin  = 0;
        expReject   = 0;

        if (mChange.size() > 0) begin
            expChgCoin  = mChange.pop_front();
            expChgValid = 1;
            mCredit    -= expChgCoin;
            expReject   = int'(coinValid);
        end else if (mItem != 0) begin
            expReject = int'(coinValid);
            if (dispReady) begin
                mItem = 0;
                buildRefund();
            end
        end else if (!mCollecting) begin
            if (coinValid) begin
                if (legalCoin(c) && c <= MAXC) begin
                    mCredit     = c;
                    mCollecting = 1;
                    mIdle       = 0;
                end else begin
                    expReject = 1;
                end
            end
        end else if (cancelReq) begin
            expReject   = int'(coinValid);
            mCollecting = 0;
            buildRefund();
        end else begin
            if (coinValid) begin
                if (legalCoin(c) && mCredit + c <= MAXC) mCredit += c;
                else expReject = 1;
            end
            if (nSel == 1 && mCredit >= price) begin
                mCredit    -= price;
                mItem       = item;
                mCollecting = 0;
            end else begin
                if (coinValid || nSel > 0) mIdle = 0;
                else mIdle++;
                if (mIdle == TIMEOUT) begin
                    mCollecting = 0;
                    buildRefund();
                end
            end
        end
    endtask

    task automatic sampleOutputs(input string tag);
        int expBusy;
        expBusy = (mCollecting || mItem != 0 || mChange.size() > 0) ? 1 : 0;
        checkOutput({tag, "_credit"},  32'(credit),       32'(mCredit));
        checkOutput({tag, "_req"},     32'(dispenseReq),  32'((mItem != 0) ? 1 : 0));
        checkOutput({tag, "_item"},    32'(dispenseItem), 32'(mItem));
        checkOutput({tag, "_chgv"},    32'(changeValid),  32'(expChgValid));
        checkOutput({tag, "_chgcoin"}, 32'(changeCoin),   32'(expChgCoin));
        checkOutput({tag, "_reject"},  32'(coinReject),   32'(expReject));
        checkOutput({tag, "_busy"},    32'(busy),         32'(expBusy));
    endtask

    // Drive one cycle of inputs on the falling edge, let the rising edge
    // happen, advance the model, and compare shortly after the edge.
    task automatic applyStimulus(input string tag, input int cv, input int cn,
                                 input int a, input int b, input int c,
                                 input int cx, input int rdy);
        @(negedge clk);
        coinValid = 1'(cv);
        coinValue = 8'(cn);
        t3        = 1'(a);
        r2        = 1'(b);
        u1        = 1'(c);
        cancelReq = 1'(cx);
        dispReady = 1'(rdy);
        @(posedge clk);
        modelStep();
        #1;
        sampleOutputs(tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        coinValid = 1'b0;
        coinValue = 8'd0;
        t3        = 1'b0;
        r2        = 1'b0;
        u1        = 1'b0;
        cancelReq = 1'b0;
        dispReady = 1'b0;
        reset     = 1'b1;
        #1;
        modelReset();
        sampleOutputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int pickCoin();
        case ($urandom_range(0, 9))
            0, 3:    return 5;
            1, 4:    return 10;
            2, 5:    return 20;
            6:       return 7;
            7:       return 0;
            8:       return 25;
            default: return 15;
        endcase
    endfunction

    task automatic randomCycle();
        int cv, cn, a, b, c, cx, rdy, s;
        cv  = ($urandom_range(0, 99) < 35) ? 1 : 0;
        cn  = pickCoin();
        s   = $urandom_range(0, 99);
        a   = (s < 8 || (s >= 24 && s < 27)) ? 1 : 0;
        b   = ((s >= 8 && s < 16) || (s >= 24 && s < 27)) ? 1 : 0;
        c   = (s >= 16 && s < 24) ? 1 : 0;
        cx  = ($urandom_range(0, 99) < 4) ? 1 : 0;
        rdy = ($urandom_range(0, 99) < 40) ? 1 : 0;
        applyStimulus("rand", cv, cn, a, b, c, cx, rdy);
    endtask

    initial begin
        reset     = 1'b1;
        coinValid = 1'b0;
        coinValue = 8'd0;
        t3        = 1'b0;
        r2        = 1'b0;
        u1        = 1'b0;
        cancelReq = 1'b0;
        dispReady = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_credit", 32'(credit), 32'd0);
        checkOutput("reset_busy",   32'(busy),   32'd0);
        checkOutput("reset_req",    32'(dispenseReq), 32'd0);
        checkOutput("reset_chgv",   32'(changeValid), 32'd0);
        reset = 1'b0;

        // Exact-price coffee, dispenser ready at once, no change.
        applyStimulus("coffee_coin", 1, 10, 0, 0, 0, 0, 0);
        applyStimulus("coffee_sel", 0, 0, 0, 1, 0, 0, 0);
        checkOutput("coffee_item_code", 32'(dispenseItem), 32'd2);
        applyStimulus("coffee_done", 0, 0, 0, 0, 0, 0, 1);
        checkOutput("coffee_idle_credit", 32'(credit), 32'd0);
        idleCycle("coffee_after");
        checkOutput("coffee_no_change", 32'(changeValid), 32'd0);

        // Tea from 40 with a slow dispenser, then change 20, 10, 5.
        applyStimulus("tea_c1", 1, 20, 0, 0, 0, 0, 0);
        applyStimulus("tea_c2", 1, 20, 0, 0, 0, 0, 0);
        applyStimulus("tea_sel", 0, 0, 1, 0, 0, 0, 0);
        applyStimulus("tea_wait1", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("tea_wait2", 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tea_req_held", 32'(dispenseReq), 32'd1);
        applyStimulus("tea_ready", 0, 0, 0, 0, 0, 0, 1);
        idleCycle("tea_chg1");
        checkOutput("tea_chg_20", 32'(changeCoin), 32'd20);
        idleCycle("tea_chg2");
        checkOutput("tea_chg_10", 32'(changeCoin), 32'd10);
        idleCycle("tea_chg3");
        checkOutput("tea_chg_5", 32'(changeCoin), 32'd5);
        checkOutput("tea_idle", 32'(busy), 32'd0);

        // Overflow and illegal coins bounce; credit holds at the ceiling.
        applyStimulus("ovf_c1", 1, 20, 0, 0, 0, 0, 0);
        applyStimulus("ovf_c2", 1, 20, 0, 0, 0, 0, 0);
        applyStimulus("ovf_c3", 1, 5, 0, 0, 0, 0, 0);
        checkOutput("ovf_reject", 32'(coinReject), 32'd1);
        checkOutput("ovf_credit", 32'(credit), 32'd40);
        applyStimulus("bad_coin", 1, 7, 0, 0, 0, 0, 0);
        checkOutput("bad_reject", 32'(coinReject), 32'd1);
        applyStimulus("ovf_cancel", 0, 0, 0, 0, 0, 1, 0);
        idleCycle("ovf_chg1");
        idleCycle("ovf_chg2");

        // Unaffordable and double selections are ignored; cancel refunds 5.
        applyStimulus("ign_coin", 1, 5, 0, 0, 0, 0, 0);
        applyStimulus("ign_lemon", 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("ign_double", 0, 0, 1, 1, 0, 0, 0);
        checkOutput("ign_still_busy", 32'(busy), 32'd1);
        applyStimulus("ign_cancel", 0, 0, 0, 0, 0, 1, 0);
        idleCycle("ign_chg");
        checkOutput("ign_chg_5", 32'(changeCoin), 32'd5);

        // Idle timeout refunds the 10.
        applyStimulus("to_coin", 1, 10, 0, 0, 0, 0, 0);
        for (int k = 0; k < TIMEOUT; k++) idleCycle("to_wait");
        idleCycle("to_chg");
        checkOutput("to_chg_valid", 32'(changeValid), 32'd1);
        checkOutput("to_chg_10", 32'(changeCoin), 32'd10);
        idleCycle("to_after");

        // Reset in DISPENSE with 15 left abandons the transaction.
        applyStimulus("rst_coin", 1, 20, 0, 0, 0, 0, 0);
        applyStimulus("rst_sel", 0, 0, 1, 0, 0, 0, 0);
        checkOutput("rst_pre_credit", 32'(credit), 32'd15);
        pulseReset("rst_mid");
        checkOutput("rst_req_drop", 32'(dispenseReq), 32'd0);
        for (int k = 0; k < 4; k++) idleCycle("rst_after");

        // Randomized traffic with occasional quiet stretches and resets.
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) begin
                pulseReset("rand_rst");
            end else if (r < 12) begin
                for (int k = 0; k < TIMEOUT + 3; k++) begin
                    applyStimulus("rand_quiet", 0, 0, 0, 0, 0, 0,
                                  int'($urandom_range(0, 1)));
                end
            end else begin
                randomCycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
